abro_n_fsm: RTL

Parametrised ABRO controller: waits for each of N event inputs to have been seen at least once, in any order and over any number of cycles, then signals O. After O it ignores further events until a restart input R re-arms it. It extends the two-input ABRO block with:
- N channels
- selectable pulse/level output
- per-channel capture visibility
- a saturating completion counter

It sits beside the other control FSMs in the same clock domain.

---
 rtl/abro_pkg.sv | 13 +
 rtl/abro_event_capture.sv | 37 +++
 rtl/abro_n_fsm.sv | 117 +++++++++++
 3 files changed

// File: rtl/abro_pkg.sv
// Shared state encodings for the ABRO controller family.
// The states are one-hot, so any value with zero or several bits set is illegal.
package abro_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_WAIT = 3'b001,
    S_FIRE = 3'b010,
    S_HOLD = 3'b100
  } state_e;

endpackage

// File: rtl/abro_event_capture.sv
// Sticky per-channel event accumulator with a synchronous clear.
// It also detects when the current edge would make every channel seen.
module abro_event_capture #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] ev,
  output logic [N-1:0] seen,
  output logic         all_seen
);

  logic [N-1:0] seen_r;
  logic [N-1:0] merged_s;

  // The detect looks at seen | ev, so a completing edge is recognised one cycle early.
  always_comb begin
    merged_s = seen_r | ev;
    all_seen = &merged_s;
  end

  // Capture register. A clear takes priority over capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_r <= '0;
    end else if (clr) begin
      seen_r <= '0;
    end else if (en) begin
      seen_r <= merged_s;
    end
  end

  assign seen = seen_r;

endmodule

// File: rtl/abro_n_fsm.sv
// N-channel ABRO controller: fires o once every channel has been seen, then waits for r.
// It also keeps a saturating count of completions since reset.
module abro_n_fsm
  import abro_pkg::*;
#(
  parameter int N          = 2,
  parameter int PULSE_MODE = 1,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       ev,
  input  logic               r,
  output logic               o,
  output logic [STATE_W-1:0] state,
  output logic [N-1:0]       seen,
  output logic [CNT_W-1:0]   done_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_r;
  state_e           state_nxt_s;
  logic             clr_s;
  logic             cap_en_s;
  logic             fire_s;
  logic             all_seen_s;
  logic             o_s;
  logic [CNT_W-1:0] done_cnt_r;

  abro_event_capture #(.N(N)) u_capture (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_s),
    .en       (cap_en_s),
    .ev       (ev),
    .seen     (seen),
    .all_seen (all_seen_s)
  );

  // Next-state and capture control. In S_WAIT, r beats a completing event on the same edge.
  always_comb begin
    state_nxt_s = S_WAIT;
    clr_s       = 1'b0;
    cap_en_s    = 1'b0;
    fire_s      = 1'b0;
    case (state_r)
      S_WAIT: begin
        if (r) begin
          clr_s       = 1'b1;
          state_nxt_s = S_WAIT;
        end else begin
          cap_en_s = 1'b1;
          if (all_seen_s) begin
            fire_s      = 1'b1;
            state_nxt_s = S_FIRE;
          end else begin
            state_nxt_s = S_WAIT;
          end
        end
      end
      S_FIRE: begin
        if (r) begin
          clr_s       = 1'b1;
          state_nxt_s = S_WAIT;
        end else begin
          state_nxt_s = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r) begin
          clr_s       = 1'b1;
          state_nxt_s = S_WAIT;
        end else begin
          state_nxt_s = S_HOLD;
        end
      end
      default: begin
        clr_s       = 1'b1;
        state_nxt_s = S_WAIT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_WAIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Completion counter. It counts up on the S_WAIT -> S_FIRE edge and sticks at its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_r <= '0;
    end else if (fire_s && (done_cnt_r != CNT_MAX)) begin
      done_cnt_r <= done_cnt_r + CNT_W'(1);
    end
  end

  // Output decode. It depends on state only, never on ev or r.
  always_comb begin
    o_s = 1'b0;
    case (state_r)
      S_FIRE:  o_s = 1'b1;
      S_HOLD:  o_s = (PULSE_MODE == 0);
      default: o_s = 1'b0;
    endcase
  end

  assign o        = o_s;
  assign state    = state_r;
  assign done_cnt = done_cnt_r;

endmodule
